// File: rtl/byte_data_rx_if.sv
// byte_data_rx_if: bundles the MAC RX byte stream and the VRAM write / frame status side
// of byte_data_rx.
//   rx_valid, rx_en, rx_data           : MAC RX byte stream (frame envelope, byte strobe, data)
//   vram_we, vram_waddr, vram_waddr_c,
//   vram_wdata                         : VRAM byte write port (pixel address, colour lane, data)
//   index_clone, startaddr             : header fields of the last accepted frame
//   busy, frame_done, frame_drop       : frame status
// The slave modport is the receiver; the master modport is the MAC/VRAM environment.
interface byte_data_rx_if;
   logic        rx_valid;
   logic        rx_en;
   logic [7:0]  rx_data;
   logic        vram_we;
   logic [19:0] vram_waddr;
   logic [1:0]  vram_waddr_c;
   logic [7:0]  vram_wdata;
   logic [7:0]  index_clone;
   logic [19:0] startaddr;
   logic        busy;
   logic        frame_done;
   logic        frame_drop;

   modport slave (
      input  rx_valid, rx_en, rx_data,
      output vram_we, vram_waddr, vram_waddr_c, vram_wdata,
      output index_clone, startaddr, busy, frame_done, frame_drop
   );

   modport master (
      output rx_valid, rx_en, rx_data,
      input  vram_we, vram_waddr, vram_waddr_c, vram_wdata,
      input  index_clone, startaddr, busy, frame_done, frame_drop
   );
endinterface

// File: rtl/byte_data_rx.sv
// byte_data_rx: receive side of the VRAM-over-UDP link. Parses an Eth/IPv4/UDP byte stream,
// checks dst MAC / ethertype / IPv4 version+IHL / protocol, latches clone id and start pixel
// address, and writes the RGB payload into VRAM one byte per write.
//   clk, rst : clock and synchronous active-high reset
//   bus      : byte_data_rx_if.slave (RX byte stream in, VRAM write port and status out)
module byte_data_rx #(
   parameter logic [47:0] MY_MAC        = 48'hdeadbeef0123,
   parameter logic [15:0] ETH_TYPE      = 16'h0800,
   parameter int unsigned PAYLOAD_BYTES = 1080,
   parameter int unsigned MAX_ADDR      = 57599
) (
   input  logic          clk,
   input  logic          rst,
   byte_data_rx_if.slave bus
);

   localparam int unsigned CNT_W   = 12;
   localparam int unsigned CNT_MAX = 4095;
   localparam int unsigned ADDR_W  = 20;
   localparam int unsigned AW1     = ADDR_W + 1;
   localparam int unsigned PAY_W   = $clog2(PAYLOAD_BYTES + 1);

   typedef enum logic [2:0] {
      SYNC,
      IDLE,
      HDR,
      PAY,
      TAIL,
      DRAIN
   } state_t;

   state_t              st_q, st_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic                mac_uni_q, mac_uni_d;
   logic                mac_bc_q, mac_bc_d;
   logic [7:0]          clone_sh_q, clone_sh_d;
   logic [ADDR_W-1:0]   saddr_sh_q, saddr_sh_d;
   logic [PAY_W-1:0]    pay_cnt_q, pay_cnt_d;
   logic [AW1-1:0]      addr_q, addr_d;   // one spare bit so overflow past MAX_ADDR stays visible
   logic [1:0]          lane_q, lane_d;

   logic                vram_we_d;
   logic [ADDR_W-1:0]   vram_waddr_d;
   logic [1:0]          vram_waddr_c_d;
   logic [7:0]          vram_wdata_d;
   logic [7:0]          index_clone_d;
   logic [ADDR_W-1:0]   startaddr_d;
   logic                busy_d;
   logic                frame_done_d;
   logic                frame_drop_d;

   logic                acc;
   logic                hdr_step;
   logic                uni_n, bc_n, fail_n;
   logic [7:0]          mac_byte;

   // A byte is taken only while the frame envelope is up.
   assign acc     = bus.rx_en && bus.rx_valid;
   assign cnt_inc = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);

   // Next-state and next-output logic.
   always_comb begin
      st_d           = st_q;
      cnt_d          = cnt_q;
      mac_uni_d      = mac_uni_q;
      mac_bc_d       = mac_bc_q;
      clone_sh_d     = clone_sh_q;
      saddr_sh_d     = saddr_sh_q;
      pay_cnt_d      = pay_cnt_q;
      addr_d         = addr_q;
      lane_d         = lane_q;
      vram_we_d      = 1'b0;
      vram_waddr_d   = bus.vram_waddr;
      vram_waddr_c_d = bus.vram_waddr_c;
      vram_wdata_d   = bus.vram_wdata;
      index_clone_d  = bus.index_clone;
      startaddr_d    = bus.startaddr;
      busy_d         = bus.busy;
      frame_done_d   = 1'b0;
      frame_drop_d   = 1'b0;
      hdr_step       = 1'b0;
      uni_n          = 1'b0;
      bc_n           = 1'b0;
      fail_n         = 1'b0;
      mac_byte       = 8'h00;

      if (acc && st_q != SYNC) begin
         cnt_d = cnt_inc;
      end

      case (st_q)
         SYNC: begin
            // Only lock on once an inter-frame gap is seen.
            if (!bus.rx_valid) begin
               st_d = IDLE;
            end
         end
         IDLE: begin
            if (acc) begin
               st_d     = HDR;
               busy_d   = 1'b1;
               hdr_step = 1'b1;
            end
         end
         HDR: begin
            if (!bus.rx_valid) begin
               st_d         = IDLE;
               busy_d       = 1'b0;
               cnt_d        = '0;
               frame_drop_d = 1'b1;
            end else if (acc) begin
               hdr_step = 1'b1;
            end
         end
         PAY: begin
            if (!bus.rx_valid) begin
               st_d         = IDLE;
               busy_d       = 1'b0;
               cnt_d        = '0;
               frame_drop_d = 1'b1;
            end else if (acc) begin
               // Writes stop for good once the pixel address runs past the frame buffer.
               if (addr_q <= AW1'(MAX_ADDR)) begin
                  vram_we_d      = 1'b1;
                  vram_waddr_d   = addr_q[ADDR_W-1:0];
                  vram_waddr_c_d = lane_q;
                  vram_wdata_d   = bus.rx_data;
               end
               if (lane_q == 2'd2) begin
                  lane_d = 2'd0;
                  addr_d = addr_q + AW1'(1);
               end else begin
                  lane_d = lane_q + 2'd1;
               end
               pay_cnt_d = pay_cnt_q + PAY_W'(1);
               if (pay_cnt_q == PAY_W'(PAYLOAD_BYTES - 1)) begin
                  st_d = TAIL;
               end
            end
         end
         TAIL: begin
            if (!bus.rx_valid) begin
               st_d         = IDLE;
               busy_d       = 1'b0;
               cnt_d        = '0;
               frame_done_d = 1'b1;
            end
         end
         DRAIN: begin
            if (!bus.rx_valid) begin
               st_d         = IDLE;
               busy_d       = 1'b0;
               cnt_d        = '0;
               frame_drop_d = 1'b1;
            end
         end
         default: begin
            st_d = SYNC;
         end
      endcase

      // Header byte handling; cnt_inc is the 1-based index of the byte being taken.
      if (hdr_step) begin
         case (cnt_inc)
            CNT_W'(1): mac_byte = MY_MAC[47:40];
            CNT_W'(2): mac_byte = MY_MAC[39:32];
            CNT_W'(3): mac_byte = MY_MAC[31:24];
            CNT_W'(4): mac_byte = MY_MAC[23:16];
            CNT_W'(5): mac_byte = MY_MAC[15:8];
            CNT_W'(6): mac_byte = MY_MAC[7:0];
            default:   mac_byte = 8'h00;
         endcase

         // Unicast and broadcast matches accumulate over all six bytes before deciding.
         uni_n = ((cnt_inc == CNT_W'(1)) || mac_uni_q) && (bus.rx_data == mac_byte);
         bc_n  = ((cnt_inc == CNT_W'(1)) || mac_bc_q) && (bus.rx_data == 8'hff);
         if (cnt_inc <= CNT_W'(6)) begin
            mac_uni_d = uni_n;
            mac_bc_d  = bc_n;
         end

         case (cnt_inc)
            CNT_W'(6):  fail_n = !(uni_n || bc_n);
            CNT_W'(13): fail_n = (bus.rx_data != ETH_TYPE[15:8]);
            CNT_W'(14): fail_n = (bus.rx_data != ETH_TYPE[7:0]);
            CNT_W'(15): fail_n = (bus.rx_data != 8'h45);
            CNT_W'(24): fail_n = (bus.rx_data != 8'h11);
            CNT_W'(35): clone_sh_d = bus.rx_data;
            CNT_W'(36): saddr_sh_d[19:16] = bus.rx_data[3:0];
            CNT_W'(37): saddr_sh_d[15:8]  = bus.rx_data;
            CNT_W'(38): saddr_sh_d[7:0]   = bus.rx_data;
            default:    fail_n = 1'b0;
         endcase

         if (fail_n) begin
            st_d = DRAIN;
         end else if (cnt_inc == CNT_W'(42)) begin
            st_d          = PAY;
            index_clone_d = clone_sh_q;
            startaddr_d   = saddr_sh_q;
            addr_d        = {1'b0, saddr_sh_q};
            lane_d        = 2'd0;
            pay_cnt_d     = '0;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q             <= SYNC;
         cnt_q            <= '0;
         mac_uni_q        <= 1'b0;
         mac_bc_q         <= 1'b0;
         clone_sh_q       <= '0;
         saddr_sh_q       <= '0;
         pay_cnt_q        <= '0;
         addr_q           <= '0;
         lane_q           <= '0;
         bus.vram_we      <= 1'b0;
         bus.vram_waddr   <= '0;
         bus.vram_waddr_c <= '0;
         bus.vram_wdata   <= '0;
         bus.index_clone  <= '0;
         bus.startaddr    <= '0;
         bus.busy         <= 1'b0;
         bus.frame_done   <= 1'b0;
         bus.frame_drop   <= 1'b0;
      end else begin
         st_q             <= st_d;
         cnt_q            <= cnt_d;
         mac_uni_q        <= mac_uni_d;
         mac_bc_q         <= mac_bc_d;
         clone_sh_q       <= clone_sh_d;
         saddr_sh_q       <= saddr_sh_d;
         pay_cnt_q        <= pay_cnt_d;
         addr_q           <= addr_d;
         lane_q           <= lane_d;
         bus.vram_we      <= vram_we_d;
         bus.vram_waddr   <= vram_waddr_d;
         bus.vram_waddr_c <= vram_waddr_c_d;
         bus.vram_wdata   <= vram_wdata_d;
         bus.index_clone  <= index_clone_d;
         bus.startaddr    <= startaddr_d;
         bus.busy         <= busy_d;
         bus.frame_done   <= frame_done_d;
         bus.frame_drop   <= frame_drop_d;
      end
   end

endmodule

// File: tb/tb_byte_data_rx.sv
// tb_byte_data_rx: scoreboard bench for byte_data_rx. Expected VRAM writes are queued as
// payload bytes are driven and compared as the DUT issues them; frame-level results
// (write count, done/drop pulses, latched header fields) are checked after each frame.
module tb_byte_data_rx;

   localparam int unsigned PAYLOAD   = 1080;
   localparam int unsigned MAXA      = 57599;
   localparam int unsigned FRAME_LEN = 42 + PAYLOAD + 4;

   logic clk;
   logic rst;

   byte_data_rx_if bus ();

   byte_data_rx dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;
   int n_writes;
   int n_done;
   int n_drop;
   int w0, d0, p0;

   logic [29:0] exp_q [$];   // {addr[19:0], lane[1:0], data[7:0]}
   logic [7:0]  fb [1:FRAME_LEN];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Write monitor and pulse checks, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.vram_we) begin
            logic [29:0] e;
            n_writes++;
            if (exp_q.size() == 0) begin
               check("write_unexpected", {12'h0, bus.vram_waddr}, 32'hffffffff);
            end else begin
               e = exp_q.pop_front();
               check("waddr", 32'(bus.vram_waddr), 32'(e[29:10]));
               check("lane", 32'(bus.vram_waddr_c), 32'(e[9:8]));
               check("wdata", 32'(bus.vram_wdata), 32'(e[7:0]));
            end
         end
         if (bus.frame_done) n_done++;
         if (bus.frame_drop) n_drop++;
         if (bus.frame_done || bus.frame_drop) begin
            check("pulse_exclusive", 32'(bus.frame_done & bus.frame_drop), 32'd0);
            check("busy_at_pulse", 32'(bus.busy), 32'd0);
         end
      end
   end

   task automatic build_frame(input bit bc, input logic [15:0] etype,
                              input logic [7:0] clone, input logic [19:0] sa);
      logic [47:0] dst;
      dst = bc ? 48'hffffffffffff : 48'hdeadbeef0123;
      for (int i = 1; i <= FRAME_LEN; i++) fb[i] = 8'h00;
      for (int i = 0; i < 6; i++) begin
         fb[1 + i] = dst[47 - 8*i -: 8];
         fb[7 + i] = 8'h02 + 8'(i);
      end
      fb[13] = etype[15:8];
      fb[14] = etype[7:0];
      fb[15] = 8'h45;
      fb[24] = 8'h11;
      fb[35] = clone;
      fb[36] = {4'ha, sa[19:16]};   // upper nibble must be ignored
      fb[37] = sa[15:8];
      fb[38] = sa[7:0];
      for (int k = 0; k < int'(PAYLOAD); k++) fb[43 + k] = 8'(k);
      for (int i = 43 + int'(PAYLOAD); i <= int'(FRAME_LEN); i++) fb[i] = 8'hc5;
   endtask

   task automatic put_byte(input logic [7:0] b, input bit gap);
      @(posedge clk); #1;
      bus.rx_en   = 1'b1;
      bus.rx_data = b;
      if (gap) begin
         @(posedge clk); #1;
         bus.rx_en   = 1'b0;
         bus.rx_data = ~b;
      end
   endtask

   // Drives bytes 1..nbytes of fb; queues expected writes when the frame should be accepted.
   task automatic drive_frame(input int nbytes, input bit good, input bit gap,
                              input logic [19:0] sa, input bit end_frame);
      @(posedge clk); #1;
      bus.rx_valid = 1'b1;
      bus.rx_en    = 1'b0;
      for (int i = 1; i <= nbytes; i++) begin
         if (good && i >= 43 && i <= 42 + int'(PAYLOAD)) begin
            int k;
            int a;
            k = i - 43;
            a = int'(sa) + k / 3;
            if (a <= int'(MAXA)) exp_q.push_back({20'(a), 2'(k % 3), fb[i]});
         end
         put_byte(fb[i], gap);
      end
      @(posedge clk); #1;
      bus.rx_en = 1'b0;
      if (end_frame) begin
         @(negedge clk);
         check("busy_in_frame", 32'(bus.busy), 32'd1);
         @(posedge clk); #1;
         bus.rx_valid = 1'b0;
         bus.rx_en    = 1'b1;   // strobe outside the envelope must be ignored
         @(posedge clk); #1;
         bus.rx_en = 1'b0;
         repeat (6) @(posedge clk);
      end
   endtask

   task automatic snap();
      w0 = n_writes;
      d0 = n_done;
      p0 = n_drop;
   endtask

   task automatic expect_frame(input int w_exp, input int done_exp, input int drop_exp,
                               input logic [7:0] clone_exp, input logic [19:0] sa_exp);
      @(negedge clk);
      check("write_count", 32'(n_writes - w0), 32'(w_exp));
      check("done_count", 32'(n_done - d0), 32'(done_exp));
      check("drop_count", 32'(n_drop - p0), 32'(drop_exp));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("index_clone", 32'(bus.index_clone), 32'(clone_exp));
      check("startaddr", 32'(bus.startaddr), 32'(sa_exp));
      check("busy_idle", 32'(bus.busy), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      n_writes = 0;
      n_done   = 0;
      n_drop   = 0;
      bus.rx_valid = 1'b0;
      bus.rx_en    = 1'b0;
      bus.rx_data  = 8'h00;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_vram_we", 32'(bus.vram_we), 32'd0);
      check("rst_waddr", 32'(bus.vram_waddr), 32'd0);
      check("rst_index_clone", 32'(bus.index_clone), 32'd0);
      check("rst_startaddr", 32'(bus.startaddr), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_pulses", 32'({bus.frame_done, bus.frame_drop}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);

      // 1: broadcast, clone 3, start 0x00100, full payload
      snap();
      build_frame(1'b1, 16'h0800, 8'd3, 20'h00100);
      drive_frame(FRAME_LEN, 1'b1, 1'b0, 20'h00100, 1'b1);
      expect_frame(int'(PAYLOAD), 1, 0, 8'd3, 20'h00100);

      // 2: wrong ethertype; previous header fields must stay
      snap();
      build_frame(1'b1, 16'h86dd, 8'd4, 20'h00200);
      drive_frame(FRAME_LEN, 1'b0, 1'b0, 20'h00200, 1'b1);
      expect_frame(0, 0, 1, 8'd3, 20'h00100);

      // 3: start near end of frame buffer; writes stop past MAX_ADDR
      snap();
      build_frame(1'b1, 16'h0800, 8'd5, 20'd57500);
      drive_frame(FRAME_LEN, 1'b1, 1'b0, 20'd57500, 1'b1);
      expect_frame(300, 1, 0, 8'd5, 20'd57500);

      // 4: truncated after byte 500, then a good frame
      snap();
      build_frame(1'b0, 16'h0800, 8'd7, 20'h02000);
      drive_frame(500, 1'b1, 1'b0, 20'h02000, 1'b1);
      expect_frame(458, 0, 1, 8'd7, 20'h02000);
      snap();
      build_frame(1'b1, 16'h0800, 8'd9, 20'h00300);
      drive_frame(FRAME_LEN, 1'b1, 1'b0, 20'h00300, 1'b1);
      expect_frame(int'(PAYLOAD), 1, 0, 8'd9, 20'h00300);

      // 5: reset mid-frame with rx_valid high; bytes after release must be ignored
      snap();
      build_frame(1'b1, 16'h0800, 8'd11, 20'h00400);
      drive_frame(30, 1'b0, 1'b0, 20'h00400, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 31; i <= 33; i++) put_byte(fb[i], 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 34; i <= 120; i++) put_byte(fb[i], 1'b0);
      @(negedge clk);
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      check("rst_mid_index_clone", 32'(bus.index_clone), 32'd0);
      check("rst_mid_startaddr", 32'(bus.startaddr), 32'd0);
      @(posedge clk); #1;
      bus.rx_en    = 1'b0;
      bus.rx_valid = 1'b0;
      repeat (4) @(posedge clk);
      expect_frame(0, 0, 0, 8'd0, 20'h00000);
      snap();
      build_frame(1'b1, 16'h0800, 8'd12, 20'h00500);
      drive_frame(FRAME_LEN, 1'b1, 1'b0, 20'h00500, 1'b1);
      expect_frame(int'(PAYLOAD), 1, 0, 8'd12, 20'h00500);

      // 6: unicast MY_MAC with gapped strobe; same writes as frame 1
      snap();
      build_frame(1'b0, 16'h0800, 8'd3, 20'h00100);
      drive_frame(FRAME_LEN, 1'b1, 1'b1, 20'h00100, 1'b1);
      expect_frame(int'(PAYLOAD), 1, 0, 8'd3, 20'h00100);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
